// File: rtl/ram_access_arbiter.sv
// Two-port round-robin arbiter that sequences single accesses to the 256x8 RAM
// array: drives MAR_BUS and the write strobe, and captures the assembled read word.
module ram_access_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mar_bus,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  // READ_WAIT is limited to 1..15, so four bits cover the settle counter.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              grant_port_reg;
  logic              we_reg;
  logic              last_grant_reg;
  logic [ADDR_W-1:0] mar_bus_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              grant_valid;
  logic              grant_port;
  logic              access_last;
  logic              capture;

  // Round-robin: on contention the port that was not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_port  = 1'b0;
    if (req0 && req1) begin
      grant_port = ~last_grant_reg;
    end else if (req1) begin
      grant_port = 1'b1;
    end
  end

  assign access_last = (state_reg == S_ACCESS) && (cnt_reg == CNT_ONE);
  assign capture     = access_last && !we_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (grant_valid) state_next = S_LOAD;
      S_LOAD:   state_next = S_ACCESS;
      S_ACCESS: if (cnt_reg == CNT_ONE) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack0   = 1'b0;
    ack1   = 1'b0;
    ram_we = 1'b0;
    busy   = (state_reg != S_IDLE);
    if (state_reg == S_DONE) begin
      ack0 = ~grant_port_reg;
      ack1 = grant_port_reg;
    end
    // The counter still holds its load value only in the first ACCESS cycle.
    if ((state_reg == S_ACCESS) && we_reg && (cnt_reg == WAIT_INIT)) begin
      ram_we = 1'b1;
    end
  end

  // Winner's request is latched at grant; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_bus_reg    <= '0;
      ram_wdata_reg  <= '0;
      we_reg         <= 1'b0;
      grant_port_reg <= 1'b0;
    end else if ((state_reg == S_IDLE) && grant_valid) begin
      grant_port_reg <= grant_port;
      if (grant_port) begin
        mar_bus_reg   <= addr1;
        ram_wdata_reg <= wdata1;
        we_reg        <= we1;
      end else begin
        mar_bus_reg   <= addr0;
        ram_wdata_reg <= wdata0;
        we_reg        <= we0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == S_LOAD) begin
      cnt_reg <= WAIT_INIT;
    end else if (state_reg == S_ACCESS) begin
      cnt_reg <= cnt_reg - CNT_ONE;
    end
  end

  // Starts at 1 so port 0 wins the first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == S_DONE) begin
      last_grant_reg <= grant_port_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (capture) begin
      rdata_reg <= ram_rdata;
    end
  end

  assign rdata     = rdata_reg;
  assign mar_bus   = mar_bus_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: stimulus pushes expected acks,
// per-instance monitors pop and compare whenever an ack appears.
module tb_ram_access_arbiter;

  typedef struct {
    int         port;
    logic [7:0] rdata;
    logic [7:0] addr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       qa[$];
  exp_t       qb[$];

  // Instance A: default READ_WAIT=1
  logic       req0, we0, ack0, req1, we1, ack1, ram_we, busy;
  logic [7:0] addr0, wdata0, addr1, wdata1, rdata, mar_bus, ram_wdata, ram_rdata;
  // Instance B: READ_WAIT=4
  logic       b_req0, b_we0, b_ack0, b_req1, b_we1, b_ack1, b_ram_we, b_busy;
  logic [7:0] b_addr0, b_wdata0, b_addr1, b_wdata1, b_rdata, b_mar_bus, b_ram_wdata, b_ram_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mar_bus(mar_bus), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_WAIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
    .rdata(b_rdata), .mar_bus(b_mar_bus), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int port, input logic [7:0] rd, input logic [7:0] addr, input int c);
    exp_t e;
    e.port = port; e.rdata = rd; e.addr = addr; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input int port, input logic [7:0] rd, input logic [7:0] addr, input int c);
    exp_t e;
    e.port = port; e.rdata = rd; e.addr = addr; e.cyc = c;
    qb.push_back(e);
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    exp_t e;
    if (ram_we) chk("a_we_only_when_busy", {31'd0, busy}, 32'd1);
    if (ack0 || ack1) begin
      chk("a_ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)", ack0, ack1, cyc);
      end else begin
        e = qa.pop_front();
        $display("A ack port %0d addr %h rdata %h cycle %0d", ack1 ? 1 : 0, mar_bus, rdata, cyc);
        chk("a_ack_port", ack1 ? 32'd1 : 32'd0, e.port);
        chk("a_ack_rdata", {24'd0, rdata}, {24'd0, e.rdata});
        chk("a_ack_addr", {24'd0, mar_bus}, {24'd0, e.addr});
        chk("a_ack_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    exp_t e;
    if (b_ack0 || b_ack1) begin
      chk("b_ack_exclusive", {31'd0, b_ack0 & b_ack1}, 32'd0);
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_ack: got ack0=%0b ack1=%0b expected none (cycle %0d)", b_ack0, b_ack1, cyc);
      end else begin
        e = qb.pop_front();
        $display("B ack port %0d addr %h rdata %h cycle %0d", b_ack1 ? 1 : 0, b_mar_bus, b_rdata, cyc);
        chk("b_ack_port", b_ack1 ? 32'd1 : 32'd0, e.port);
        chk("b_ack_rdata", {24'd0, b_rdata}, {24'd0, e.rdata});
        chk("b_ack_addr", {24'd0, b_mar_bus}, {24'd0, e.addr});
        chk("b_ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
    chk({tag, "_mar_bus"}, {24'd0, mar_bus}, 32'd0);
    chk({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, ram_we, ack0, ack1, busy}, 32'd0);
  endtask

  // One isolated transaction on instance A; inputs are scrambled after grant.
  task automatic run_single(input bit port, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] rd,
                            input logic [7:0] exp_rd, input string tag);
    int t0;
    logic [4:0] bmask, wmask;
    logic [7:0] mar1;
    t0 = cyc;
    ram_rdata = rd;
    if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
    push_a(port, exp_rd, addr, t0 + 3);
    for (int k = 0; k < 5; k++) begin
      bmask[k] = busy;
      wmask[k] = ram_we;
      if (k == 1) begin
        mar1 = mar_bus;
        addr0 = ~addr; addr1 = ~addr; wdata0 = ~wdata; wdata1 = ~wdata;
        we0 = ~we; we1 = ~we;
      end
      if (k == 3) begin req0 = 0; req1 = 0; end
      step();
    end
    chk({tag, "_mar_cycle1"}, {24'd0, mar1}, {24'd0, addr});
    chk({tag, "_busy_mask"}, {27'd0, bmask}, 32'h0E);
    chk({tag, "_we_mask"}, {27'd0, wmask}, we ? 32'h04 : 32'h00);
    if (we) chk({tag, "_ram_wdata"}, {24'd0, ram_wdata}, {24'd0, wdata});
  endtask

  initial begin
    int t0;
    logic [16:0] bm3;
    logic [16:0] exp3;
    logic [7:0]  bm4;
    logic [8:0]  bm6;
    logic [8:0]  bm5;

    rst_n = 0;
    {req0, we0, req1, we1} = '0;
    {addr0, wdata0, addr1, wdata1, ram_rdata} = '0;
    {b_req0, b_we0, b_req1, b_we1} = '0;
    {b_addr0, b_wdata0, b_addr1, b_wdata1, b_ram_rdata} = '0;
    step();
    step();
    chk_reset_a("reset_a");
    chk("reset_b_outputs", {b_rdata, b_mar_bus, b_ram_wdata, b_ram_we, b_ack0, b_ack1, b_busy}, 32'd0);
    rst_n = 1;
    step();

    // 1) read addr 00 on port 0
    run_single(1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5, "t1");
    // 2) write addr FF on port 1; rdata unchanged
    run_single(1'b1, 1'b1, 8'hFF, 8'h3C, 8'h77, 8'hA5, "t2");
    chk("t2_rdata_kept", {24'd0, rdata}, 32'hA5);

    // 3) contention from reset, both held
    rst_n = 0;
    #1;
    chk_reset_a("t3_reset");
    step();
    rst_n = 1;
    step();
    t0 = cyc;
    ram_rdata = 8'h5A;
    req0 = 1; we0 = 0; addr0 = 8'h10;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    push_a(0, 8'h5A, 8'h10, t0 + 3);
    push_a(1, 8'h5A, 8'h20, t0 + 7);
    push_a(0, 8'h5A, 8'h10, t0 + 11);
    push_a(1, 8'h5A, 8'h20, t0 + 15);
    for (int k = 0; k < 17; k++) begin
      bm3[k] = busy;
      exp3[k] = (k % 4) != 0;
      if (k == 15) begin req0 = 0; req1 = 0; end
      step();
    end
    chk("t3_busy_mask", {15'd0, bm3}, {15'd0, exp3});

    // 4) READ_WAIT=4 read with late-changing read word
    t0 = cyc;
    b_ram_rdata = 8'h11;
    b_req0 = 1; b_we0 = 0; b_addr0 = 8'h80;
    push_b(0, 8'h22, 8'h80, t0 + 6);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) b_ram_rdata = 8'h22;
      bm4[k] = b_busy;
      if (k == 6) b_req0 = 0;
      step();
    end
    chk("t4_busy_mask", {24'd0, bm4}, 32'h7E);
    chk("t4_rdata_held", {24'd0, b_rdata}, 32'h22);

    // 6) req0 dropped mid-read; req1 raised while busy
    t0 = cyc;
    ram_rdata = 8'hC3;
    req0 = 1; we0 = 0; addr0 = 8'h33;
    push_a(0, 8'hC3, 8'h33, t0 + 3);
    push_a(1, 8'hC3, 8'h44, t0 + 7);
    for (int k = 0; k < 9; k++) begin
      bm6[k] = busy;
      if (k == 2) begin req0 = 0; req1 = 1; we1 = 0; addr1 = 8'h44; end
      if (k == 7) req1 = 0;
      step();
    end
    chk("t6_busy_mask", {23'd0, bm6}, 32'h0EE);

    // Port 0 write so last_grant is 0 before the reset test
    run_single(1'b0, 1'b1, 8'h01, 8'hE7, 8'h5F, 8'hC3, "t6w");

    // 5) reset during an in-flight read, then contention after release
    ram_rdata = 8'h99;
    req0 = 1; we0 = 0; addr0 = 8'h42;
    step();
    step();
    #2;
    rst_n = 0;
    #1;
    chk_reset_a("t5_reset");
    req0 = 0;
    step();
    step();
    rst_n = 1;
    step();
    t0 = cyc;
    ram_rdata = 8'h6D;
    req0 = 1; we0 = 0; addr0 = 8'h05;
    req1 = 1; we1 = 0; addr1 = 8'h06;
    push_a(0, 8'h6D, 8'h05, t0 + 3);
    push_a(1, 8'h6D, 8'h06, t0 + 7);
    for (int k = 0; k < 9; k++) begin
      bm5[k] = busy;
      if (k == 3) req0 = 0;
      if (k == 7) req1 = 0;
      step();
    end
    chk("t5_busy_mask", {23'd0, bm5}, 32'h0EE);

    step();
    step();
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
